// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operator encodings, widths, exponent limits and
// the record carried between the normalise pipeline stages.
package fpu_pkg;

  localparam int unsigned MANT_W = 32'd48;
  localparam int unsigned EXP_W  = 32'd8;
  localparam int unsigned FRAC_W = 32'd23;

  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_MAX  = 10'sd255;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef struct packed {
    logic              valid;
    logic              sign;
    logic signed [9:0] exp;
    logic [47:0]       mant;
    logic              sticky;
    op_e               op;
    logic              zero;
  } stage_t;

endpackage

// File: rtl/fpu_normalize_if.sv
// Upstream/downstream handshake bundle of the normalise stage; the slave
// modport is the normaliser, the master modport is whoever drives it.
interface fpu_normalize_if;
  import fpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exponent;
  logic [MANT_W-1:0] in_mantissa;
  logic [1:0]        in_operator;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [1:0]        out_operator;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_zero;

  modport slave (
    input  in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
    output in_ready, out_valid, out_result, out_operator,
           out_overflow, out_underflow, out_zero
  );

  modport master (
    output in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
    input  in_ready, out_valid, out_result, out_operator,
           out_overflow, out_underflow, out_zero
  );

endinterface

// File: rtl/fpu_lzc48.sv
// Combinational 48-bit leading-one detector: bit index of the highest set
// bit, plus a flag for an all-zero word.
module fpu_lzc48 (
  input  logic [47:0] mant_i,
  output logic [5:0]  pos_o,
  output logic        zero_o
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    pos_o = 6'd0;
    for (int i = 0; i < 48; i++) begin
      pos_o = mant_i[i] ? 6'(i) : pos_o;
    end
    zero_o = ~|mant_i;
  end

endmodule

// File: rtl/fpu_normalize.sv
// Three-stage normalise / round-to-nearest-even / pack of the fpu_compute
// result into an IEEE-754 single, with one global stall for all stages.
module fpu_normalize
  import fpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fpu_normalize_if.slave bus
);

  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;

  logic        out_valid_q,     out_valid_d;
  logic [31:0] out_result_q,    out_result_d;
  logic [1:0]  out_operator_q,  out_operator_d;
  logic        out_overflow_q,  out_overflow_d;
  logic        out_underflow_q, out_underflow_d;
  logic        out_zero_q,      out_zero_d;

  logic              advance_s;
  logic [5:0]        lead_pos_s;
  logic              lead_zero_s;
  logic [5:0]        lshift_s;
  logic [MANT_W-1:0] norm_mant_s;
  logic signed [9:0] norm_exp_s;
  logic              norm_sticky_s;
  logic              guard_s;
  logic              sticky_s;
  logic              inc_s;
  logic [24:0]       rnd_sum_s;
  logic [22:0]       rnd_frac_s;
  logic signed [9:0] rnd_exp_s;

  assign advance_s          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready       = advance_s;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_operator   = out_operator_q;
  assign bus.out_overflow   = out_overflow_q;
  assign bus.out_underflow  = out_underflow_q;
  assign bus.out_zero       = out_zero_q;

  fpu_lzc48 u_lzc (
    .mant_i (s1_q.mant),
    .pos_o  (lead_pos_s),
    .zero_o (lead_zero_s)
  );

  // S1 capture of the raw compute result.
  always_comb begin
    s1_d = s1_q;
    if (advance_s) begin
      s1_d.valid  = bus.in_valid;
      s1_d.sign   = bus.in_sign;
      s1_d.exp    = $signed({2'b00, bus.in_exponent});
      s1_d.mant   = bus.in_mantissa;
      s1_d.sticky = 1'b0;
      s1_d.op     = op_e'(bus.in_operator);
      s1_d.zero   = (bus.in_mantissa == 48'd0);
    end else begin
      s1_d = s1_q;
    end
  end

  // Normalise so that bit 46 holds the hidden one.
  always_comb begin
    lshift_s      = 6'd46 - lead_pos_s;
    norm_mant_s   = s1_q.mant;
    norm_exp_s    = s1_q.exp;
    norm_sticky_s = s1_q.sticky;
    if (s1_q.mant[47]) begin
      norm_mant_s   = {1'b0, s1_q.mant[47:1]};
      norm_exp_s    = s1_q.exp + 10'sd1;
      norm_sticky_s = s1_q.sticky | s1_q.mant[0];
    end else if (!lead_zero_s && (lead_pos_s < 6'd46)) begin
      norm_mant_s   = s1_q.mant << lshift_s;
      norm_exp_s    = s1_q.exp - $signed({4'd0, lshift_s});
    end else begin
      norm_mant_s   = s1_q.mant;
    end
  end

  // S2 register of the normalised value.
  always_comb begin
    s2_d = s2_q;
    if (advance_s) begin
      s2_d.valid  = s1_q.valid;
      s2_d.sign   = s1_q.sign;
      s2_d.exp    = norm_exp_s;
      s2_d.mant   = norm_mant_s;
      s2_d.sticky = norm_sticky_s;
      s2_d.op     = s1_q.op;
      s2_d.zero   = s1_q.zero;
    end else begin
      s2_d = s2_q;
    end
  end

  // Round to nearest even; a carry out of the significand renormalises by one.
  always_comb begin
    guard_s   = s2_q.mant[22];
    sticky_s  = (|s2_q.mant[21:0]) | s2_q.sticky;
    inc_s     = guard_s & (sticky_s | s2_q.mant[23]);
    rnd_sum_s = {s2_q.mant[47], s2_q.mant[46:23]} + {24'd0, inc_s};
    if (rnd_sum_s[24]) begin
      rnd_frac_s = rnd_sum_s[23:1];
      rnd_exp_s  = s2_q.exp + 10'sd1;
    end else begin
      rnd_frac_s = rnd_sum_s[22:0];
      rnd_exp_s  = s2_q.exp;
    end
  end

  // S3 pack with saturation to infinity and flush to zero.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_operator_d  = out_operator_q;
    out_overflow_d  = out_overflow_q;
    out_underflow_d = out_underflow_q;
    out_zero_d      = out_zero_q;
    if (advance_s) begin
      out_valid_d = s2_q.valid;
      if (s2_q.valid) begin
        out_operator_d = s2_q.op;
        if (s2_q.zero) begin
          out_result_d    = {s2_q.sign, 31'd0};
          out_overflow_d  = 1'b0;
          out_underflow_d = 1'b0;
          out_zero_d      = 1'b1;
        end else if (rnd_exp_s >= EXP_MAX) begin
          out_result_d    = {s2_q.sign, 8'hFF, 23'd0};
          out_overflow_d  = 1'b1;
          out_underflow_d = 1'b0;
          out_zero_d      = 1'b0;
        end else if (rnd_exp_s <= 10'sd0) begin
          out_result_d    = {s2_q.sign, 31'd0};
          out_overflow_d  = 1'b0;
          out_underflow_d = 1'b1;
          out_zero_d      = 1'b1;
        end else begin
          out_result_d    = {s2_q.sign, rnd_exp_s[7:0], rnd_frac_s};
          out_overflow_d  = 1'b0;
          out_underflow_d = 1'b0;
          out_zero_d      = 1'b0;
        end
      end else begin
        out_result_d = out_result_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q            <= '0;
      s2_q            <= '0;
      out_valid_q     <= 1'b0;
      out_result_q    <= 32'd0;
      out_operator_q  <= 2'b00;
      out_overflow_q  <= 1'b0;
      out_underflow_q <= 1'b0;
      out_zero_q      <= 1'b0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_operator_q  <= out_operator_d;
      out_overflow_q  <= out_overflow_d;
      out_underflow_q <= out_underflow_d;
      out_zero_q      <= out_zero_d;
    end
  end

endmodule

// File: doc/fpu_normalize.md
Name: fpu_normalize

Overview:
- Post-compute stage of the FPU pipeline, directly downstream of fpu_compute.
- Takes the unnormalised sign, exponent and 48-bit mantissa from fpu_compute and normalises, rounds and packs them into an IEEE-754 single-precision word.
- 3-stage pipeline with valid/ready handshake on both sides; passes the operator field through as sideband.

Parameters:
- MANT_W, 48, input mantissa width; binary point sits between bits 46 and 45.
- EXP_W, 8, biased exponent width.
- FRAC_W, 23, output fraction width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept this cycle
- in_sign  in  1  result sign from fpu_compute
- in_exponent  in  8  biased exponent from fpu_compute, before normalisation
- in_mantissa  in  48  unnormalised mantissa, format xx.(46 bits)
- in_operator  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  packed result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  {sign, exp[7:0], frac[22:0]}
- out_operator  out  2  operator passed through
- out_overflow  out  1  result saturated to infinity
- out_underflow  out  1  result flushed to zero by underflow
- out_zero  out  1  result is signed zero

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0; out_valid=0, out_result=0, out_operator=0, all flags 0. Reset mid-operation discards in-flight data; no output is produced for it.
- Global stall: advance = !out_valid | out_ready; in_ready = advance. All three stages load only when advance=1. Bubbles are not compressed.
- Latency: 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no stall. Throughput is 1 per cycle.
- S1:
  - Register the inputs.
  - Compute leading-one position p of the mantissa with fpu_lzc48.
  - Exponent is carried internally as a 10-bit signed value.
  - Set zero flag when the mantissa is 0.
- S2, normalise:
  - If bit47=1: shift right 1 and add 1 to the exponent. The shifted-out bit joins sticky.
  - Else if p<46: shift left by 46-p and subtract 46-p from the exponent.
  - Else: no shift.
  - After S2, bit46 is the hidden 1 and bits 45:23 are the fraction.
- S3, round and pack:
  - Round to nearest, ties to even: guard = bit22, sticky = OR(bits 21:0, right-shift sticky), lsb = bit23.
  - Increment when guard & (sticky | lsb).
  - If the increment carries into bit47, shift right 1 and add 1 to the exponent.
- Overflow: final exponent >= 255 → exp=255, frac=0, out_overflow=1.
- Underflow: final exponent <= 0 with non-zero mantissa → exp=0, frac=0, out_underflow=1, out_zero=1. No subnormals are produced.
- Zero input mantissa → {in_sign, 31'b0}, out_zero=1, no flags otherwise. The exponent is ignored.
- Sign is passed through unchanged in every case, including zero, underflow and infinity.
- While out_valid=1 & out_ready=0, every output holds stable.

Decomposition:
- Shared package fpu_pkg:
  - operator encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - EXP_BIAS=127, EXP_MAX=255
  - width constants MANT_W, EXP_W, FRAC_W
  - the pipeline stage record (valid, sign, exp[9:0] signed, mant[47:0], sticky, operator, zero)
- One sub-module, fpu_lzc48: combinational 48-bit leading-one detector. Outputs a 6-bit position and an all-zero flag.

Test Plan:
- Add, exp=8'h7F, mantissa=48'hB000_0000_0000 (2.75) → out_result=32'h4030_0000, no flags, out_valid exactly 3 cycles after acceptance.
- Mul, exp=8'h7F, mantissa=48'h9000_0000_0000 (1.5×1.5) → 32'h4010_0000, out_operator=2'b10.
- Sub cancellation, exp=8'h7F, mantissa=48'h0000_0080_0000 → left shift by 23 → 32'h3400_0000. Also mantissa=0 with sign=1 → 32'h8000_0000, out_zero=1.
- Rounding:
  - mantissa=48'h4000_00C0_0000, exp=8'h7F → 32'h3F80_0002 (tie, odd lsb rounds up).
  - mantissa=48'h4000_0040_0000 → 32'h3F80_0000 (tie, even lsb holds).
- Overflow: exp=8'hFE, mantissa=48'hC000_0000_0000 → 32'h7F80_0000, out_overflow=1.
- Backpressure and reset:
  - Stream 5 back-to-back inputs and hold out_ready=0 for 4 cycles → out_valid and out_result stay stable, in_ready=0. All 5 results emerge in order once out_ready=1.
  - Assert rst_n=0 mid-stream → out_valid=0 immediately; no stale result after release.
